// File: rtl/keccak_pkg.sv
// Shared Keccak definitions: lane geometry, rho offset table and the
// inverse-rho controller state encoding.
package keccak_pkg;

  localparam int LANE_W    = 64;
  localparam int NUM_LANES = 25;
  localparam int ADDR_W    = 5;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_INIT   = 3'd1,
    ST_FETCH  = 3'd2,
    ST_LOAD   = 3'd3,
    ST_ROTATE = 3'd4,
    ST_WRITE  = 3'd5,
    ST_NEXT   = 3'd6,
    ST_DONE   = 3'd7
  } inv_rho_state_e;

  localparam logic [7:0] RHO_TABLE [NUM_LANES] = '{
    8'd0,  8'd1,  8'd62, 8'd28, 8'd27,
    8'd36, 8'd44, 8'd6,  8'd55, 8'd20,
    8'd3,  8'd10, 8'd43, 8'd25, 8'd39,
    8'd41, 8'd45, 8'd15, 8'd21, 8'd8,
    8'd18, 8'd2,  8'd61, 8'd56, 8'd14
  };

  // Out-of-range lane indices map to a zero offset rather than an X.
  function automatic logic [7:0] rho_offset(input logic [ADDR_W-1:0] lane);
    logic [7:0] off;
    if (lane < ADDR_W'(NUM_LANES)) begin
      off = RHO_TABLE[lane];
    end else begin
      off = 8'd0;
    end
    return off;
  endfunction

endpackage

// File: rtl/inv_rho_unit_if.sv
// Control handshake plus source-read / destination-write ports of inv_rho_unit.
interface inv_rho_unit_if #(
  parameter int LANE_W = keccak_pkg::LANE_W,
  parameter int ADDR_W = keccak_pkg::ADDR_W
);
  logic              start;
  logic              ready;
  logic              done;
  logic [ADDR_W-1:0] rd_addr;
  logic [LANE_W-1:0] rd_data;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [LANE_W-1:0] wr_data;

  modport master (
    input  start, rd_data,
    output ready, done, rd_addr, wr_en, wr_addr, wr_data
  );

  modport slave (
    output start, rd_data,
    input  ready, done, rd_addr, wr_en, wr_addr, wr_data
  );
endinterface

// File: rtl/inv_rho_cu.sv
// Sequencing FSM of inv_rho_unit; strobes are Moore-decoded from the state
// register so reset removes them asynchronously.
module inv_rho_cu
  import keccak_pkg::*;
(
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic           rot_zero,
  input  logic           last_lane,
  output inv_rho_state_e state,
  output logic           ready,
  output logic           done,
  output logic           wr_en
);

  inv_rho_state_e state_r;
  inv_rho_state_e next_s;

  // state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_s;
    end
  end

  // next-state decode
  always_comb begin
    next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          next_s = ST_INIT;
        end else begin
          next_s = ST_IDLE;
        end
      end
      ST_INIT:  next_s = ST_FETCH;
      ST_FETCH: next_s = ST_LOAD;
      ST_LOAD:  next_s = ST_ROTATE;
      ST_ROTATE: begin
        if (rot_zero) begin
          next_s = ST_WRITE;
        end else begin
          next_s = ST_ROTATE;
        end
      end
      ST_WRITE: begin
        if (last_lane) begin
          next_s = ST_DONE;
        end else begin
          next_s = ST_NEXT;
        end
      end
      ST_NEXT: next_s = ST_FETCH;
      ST_DONE: next_s = ST_IDLE;
      default: next_s = ST_IDLE;
    endcase
  end

  // Moore output decode
  always_comb begin
    ready = 1'b0;
    done  = 1'b0;
    wr_en = 1'b0;
    case (state_r)
      ST_IDLE:  ready = 1'b1;
      ST_WRITE: wr_en = 1'b1;
      ST_DONE:  done  = 1'b1;
      default: begin
        ready = 1'b0;
        done  = 1'b0;
        wr_en = 1'b0;
      end
    endcase
  end

  assign state = state_r;

endmodule

// File: rtl/inv_rho_unit.sv
// Inverse Keccak rho: rotates each of the 25 lanes right by its rho offset.
// Define INV_RHO_BARREL_EN for a single-cycle barrel rotate instead of bit-serial.
module inv_rho_unit #(
  parameter int LANE_W    = keccak_pkg::LANE_W,
  parameter int NUM_LANES = keccak_pkg::NUM_LANES,
  parameter int ADDR_W    = keccak_pkg::ADDR_W
) (
  input  logic           clk,
  input  logic           reset,
  inv_rho_unit_if.master bus
);
  import keccak_pkg::*;

  localparam int                ROT_W     = $clog2(LANE_W);
  localparam logic [ADDR_W-1:0] LAST_LANE = ADDR_W'(NUM_LANES - 1);

  inv_rho_state_e    state_s;
  logic              rot_zero_s;
  logic              last_lane_s;
  logic              ready_s;
  logic              done_s;
  logic              wr_en_s;
  logic [ADDR_W-1:0] lane_cnt_r;
  logic [LANE_W-1:0] lane_r;
  logic [ROT_W-1:0]  offset_s;

  inv_rho_cu u_cu (
    .clk       (clk),
    .reset     (reset),
    .start     (bus.start),
    .rot_zero  (rot_zero_s),
    .last_lane (last_lane_s),
    .state     (state_s),
    .ready     (ready_s),
    .done      (done_s),
    .wr_en     (wr_en_s)
  );

  // rotation amount for the current lane, reduced modulo the lane width
  always_comb begin
    offset_s = ROT_W'({24'd0, rho_offset(lane_cnt_r)} % 32'(LANE_W));
  end

  assign last_lane_s = (lane_cnt_r == LAST_LANE);

  // lane counter: cleared in INIT, advanced in NEXT, saturates at the last lane
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lane_cnt_r <= '0;
    end else begin
      case (state_s)
        ST_INIT: lane_cnt_r <= '0;
        ST_NEXT: begin
          if (lane_cnt_r != LAST_LANE) begin
            lane_cnt_r <= lane_cnt_r + ADDR_W'(1);
          end else begin
            lane_cnt_r <= lane_cnt_r;
          end
        end
        default: lane_cnt_r <= lane_cnt_r;
      endcase
    end
  end

`ifdef INV_RHO_BARREL_EN
  // lane register: capture in LOAD, one full barrel rotate in ROTATE
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lane_r <= '0;
    end else begin
      case (state_s)
        ST_LOAD:   lane_r <= bus.rd_data;
        ST_ROTATE: lane_r <= LANE_W'({lane_r, lane_r} >> offset_s);
        default:   lane_r <= lane_r;
      endcase
    end
  end

  assign rot_zero_s = 1'b1;
`else
  logic [ROT_W-1:0] rot_cnt_r;

  // lane register: capture in LOAD, one-bit right rotate per ROTATE cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lane_r <= '0;
    end else begin
      case (state_s)
        ST_LOAD: lane_r <= bus.rd_data;
        ST_ROTATE: begin
          if (rot_cnt_r != '0) begin
            lane_r <= {lane_r[0], lane_r[LANE_W-1:1]};
          end else begin
            lane_r <= lane_r;
          end
        end
        default: lane_r <= lane_r;
      endcase
    end
  end

  // rotate counter: remaining single-bit shifts for the current lane
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rot_cnt_r <= '0;
    end else begin
      case (state_s)
        ST_LOAD: rot_cnt_r <= offset_s;
        ST_ROTATE: begin
          if (rot_cnt_r != '0) begin
            rot_cnt_r <= rot_cnt_r - ROT_W'(1);
          end else begin
            rot_cnt_r <= rot_cnt_r;
          end
        end
        default: rot_cnt_r <= rot_cnt_r;
      endcase
    end
  end

  assign rot_zero_s = (rot_cnt_r == '0);
`endif

  // Addresses and write data come straight from registers; reads and writes
  // of a lane never overlap, so in-place operation on one memory is safe.
  assign bus.ready   = ready_s;
  assign bus.done    = done_s;
  assign bus.wr_en   = wr_en_s;
  assign bus.rd_addr = lane_cnt_r;
  assign bus.wr_addr = lane_cnt_r;
  assign bus.wr_data = lane_r;

endmodule

// File: tb/tb_inv_rho_unit.sv
// Self-checking bench for inv_rho_unit: directed single-lane vectors, random
// round trips against a rotate-left/rotate-right model, busy start, reset mid-pass.
module tb_inv_rho_unit;

  localparam logic [63:0] FILL = 64'hA5A5_5A5A_C3C3_3C3C;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  inv_rho_unit_if bus ();

  inv_rho_unit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int rho_ref [25] = '{0, 1, 62, 28, 27, 36, 44, 6, 55, 20, 3, 10, 43, 25, 39,
                       41, 45, 15, 21, 8, 18, 2, 61, 56, 14};

  logic [63:0] src_mem [25];
  logic [63:0] dst_mem [25];
  logic [63:0] orig    [25];
  int  wr_count   = 0;
  int  done_count = 0;
  int  bad_addr   = 0;
  bit  clr_req    = 1'b0;
  bit  clr_copy   = 1'b0;
  bit  inplace    = 1'b0;
  int  tests      = 0;
  int  fails      = 0;

  typedef struct {
    int          lane;
    logic [63:0] val;
    logic [63:0] exp;
  } vec_t;
  vec_t vecs [7];

  // memory model: synchronous read, write port, event counters
  always @(posedge clk) begin
    if (clr_req) begin
      for (int i = 0; i < 25; i++) dst_mem[i] <= clr_copy ? src_mem[i] : FILL;
    end else begin
      if (bus.wr_en) begin
        if (bus.wr_addr < 5'd25) dst_mem[bus.wr_addr] <= bus.wr_data;
        else bad_addr <= bad_addr + 1;
        wr_count <= wr_count + 1;
      end
      if (bus.done) done_count <= done_count + 1;
    end
    if (bus.rd_addr < 5'd25) bus.rd_data <= inplace ? dst_mem[bus.rd_addr] : src_mem[bus.rd_addr];
    else bus.rd_data <= 64'd0;
  end

  function automatic logic [63:0] rotr64(input logic [63:0] x, input int n);
    int k = n % 64;
    if (k == 0) return x;
    return (x >> k) | (x << (64 - k));
  endfunction

  function automatic logic [63:0] rotl64(input logic [63:0] x, input int n);
    int k = n % 64;
    if (k == 0) return x;
    return (x << k) | (x >> (64 - k));
  endfunction

  // Window: the IDLE cycle presenting start through the IDLE cycle after done.
  function automatic int exp_cycles();
    int s = 0;
    for (int i = 0; i < 25; i++) begin
`ifdef INV_RHO_BARREL_EN
      s += 5;
`else
      s += 5 + rho_ref[i];
`endif
    end
    return 2 + s + 1;
  endfunction

  function automatic int image_errs();
    int e = 0;
    for (int i = 0; i < 25; i++) if (dst_mem[i] !== rotr64(src_mem[i], rho_ref[i]) || dst_mem[i] !== orig[i]) e++;
    return e;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: actual %h required %h", name, act, exp);
    end
  endtask

  task automatic clear_dst(input bit copy);
    @(negedge clk);
    clr_copy = copy;
    clr_req  = 1'b1;
    @(negedge clk);
    clr_req  = 1'b0;
  endtask

  task automatic load_random();
    for (int i = 0; i < 25; i++) begin
      orig[i]    = {$urandom(), $urandom()};
      src_mem[i] = rotl64(orig[i], rho_ref[i]);
    end
  endtask

  task automatic run_pass(output int cycles, output bit timed_out);
    int edges;
    @(negedge clk);
    bus.start = 1'b1;
    @(posedge clk);
    edges = 1;
    #1 bus.start = 1'b0;
    while (!bus.ready && edges < 5000) begin
      @(posedge clk);
      edges++;
      #1;
    end
    timed_out = !bus.ready;
    cycles = edges + 1;
  endtask

  task automatic wait_wr(input logic [4:0] lane, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 4000 && !ok; n++) begin
      @(negedge clk);
      if (bus.wr_en && bus.wr_addr == lane) ok = 1'b1;
    end
  endtask

  task automatic wait_ready(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 5000 && !ok; n++) begin
      @(negedge clk);
      if (bus.ready) ok = 1'b1;
    end
  endtask

  initial begin
    int  cyc, w0, d0, bad;
    bit  to, ok;

    vecs[0] = '{1,  64'h2,                   64'h1};
    vecs[1] = '{2,  64'h1,                   64'h4};
    vecs[2] = '{0,  64'hDEADBEEF_00000001,   64'hDEADBEEF_00000001};
    vecs[3] = '{5,  64'h1,                   64'h0000_0000_1000_0000};
    vecs[4] = '{8,  64'h80,                  64'h1_0000};
    vecs[5] = '{22, 64'h8,                   64'h40};
    vecs[6] = '{24, 64'h4000,                64'h1};

    reset = 1'b1;
    bus.start = 1'b0;
    for (int i = 0; i < 25; i++) begin
      src_mem[i] = 64'd0;
      orig[i]    = 64'd0;
    end
    repeat (2) @(negedge clk);
    check("rst ready",   64'(bus.ready),   64'd1);
    check("rst done",    64'(bus.done),    64'd0);
    check("rst wr_en",   64'(bus.wr_en),   64'd0);
    check("rst rd_addr", 64'(bus.rd_addr), 64'd0);
    check("rst wr_addr", 64'(bus.wr_addr), 64'd0);
    check("rst wr_data", bus.wr_data,      64'd0);
    reset = 1'b0;
    @(negedge clk);
    check("idle ready", 64'(bus.ready), 64'd1);

    // directed single-lane vectors
    for (int v = 0; v < 7; v++) begin
      for (int i = 0; i < 25; i++) src_mem[i] = 64'd0;
      src_mem[vecs[v].lane] = vecs[v].val;
      clear_dst(1'b0);
      w0 = wr_count;
      d0 = done_count;
      run_pass(cyc, to);
      @(negedge clk);
      bad = 0;
      for (int i = 0; i < 25; i++) if (i != vecs[v].lane && dst_mem[i] !== 64'd0) bad++;
      check($sformatf("vec%0d timeout", v), 64'(to), 64'd0);
      check($sformatf("vec%0d lane %0d", v, vecs[v].lane), dst_mem[vecs[v].lane], vecs[v].exp);
      check($sformatf("vec%0d other lanes", v), 64'(bad), 64'd0);
      check($sformatf("vec%0d done pulses", v), 64'(done_count - d0), 64'd1);
      check($sformatf("vec%0d writes", v), 64'(wr_count - w0), 64'd25);
      check($sformatf("vec%0d ready", v), 64'(bus.ready), 64'd1);
      check($sformatf("vec%0d cycles", v), 64'(cyc), 64'(exp_cycles()));
    end

    // random round trips through forward rho then the unit
    for (int r = 0; r < 3; r++) begin
      load_random();
      clear_dst(1'b0);
      run_pass(cyc, to);
      @(negedge clk);
      check($sformatf("round%0d timeout", r), 64'(to), 64'd0);
      check($sformatf("round%0d image errs", r), 64'(image_errs()), 64'd0);
      check($sformatf("round%0d cycles", r), 64'(cyc), 64'(exp_cycles()));
    end

    // in-place: source and destination are the same memory
    load_random();
    clear_dst(1'b1);
    inplace = 1'b1;
    run_pass(cyc, to);
    @(negedge clk);
    inplace = 1'b0;
    check("inplace timeout", 64'(to), 64'd0);
    check("inplace image errs", 64'(image_errs()), 64'd0);

    // start pulsed while rotating lane 5 must be ignored
    load_random();
    clear_dst(1'b0);
    w0 = wr_count;
    d0 = done_count;
    @(negedge clk) bus.start = 1'b1;
    @(negedge clk) bus.start = 1'b0;
    wait_wr(5'd4, ok);
    check("busy reach lane4", 64'(ok), 64'd1);
    repeat (4) @(negedge clk);
    bus.start = 1'b1;
    check("busy not ready", 64'(bus.ready), 64'd0);
    @(negedge clk) bus.start = 1'b0;
    wait_ready(ok);
    repeat (3) @(negedge clk);
    check("busy finish", 64'(ok), 64'd1);
    check("busy writes", 64'(wr_count - w0), 64'd25);
    check("busy done pulses", 64'(done_count - d0), 64'd1);
    check("busy image errs", 64'(image_errs()), 64'd0);

    // reset during the write of lane 10, then a full clean pass
    load_random();
    clear_dst(1'b0);
    @(negedge clk) bus.start = 1'b1;
    @(negedge clk) bus.start = 1'b0;
    wait_wr(5'd10, ok);
    check("rstmid reach lane10", 64'(ok), 64'd1);
    reset = 1'b1;
    #1;
    check("rstmid wr_en", 64'(bus.wr_en), 64'd0);
    check("rstmid ready", 64'(bus.ready), 64'd1);
    @(negedge clk) reset = 1'b0;
    @(negedge clk);
    check("rstmid ready after", 64'(bus.ready), 64'd1);
    clear_dst(1'b0);
    w0 = wr_count;
    d0 = done_count;
    run_pass(cyc, to);
    @(negedge clk);
    check("rstmid pass timeout", 64'(to), 64'd0);
    check("rstmid image errs", 64'(image_errs()), 64'd0);
    check("rstmid writes", 64'(wr_count - w0), 64'd25);
    check("rstmid done pulses", 64'(done_count - d0), 64'd1);
    check("rstmid cycles", 64'(cyc), 64'(exp_cycles()));

    check("address range", 64'(bad_addr), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
